bp_clint_ctrl: RTL and testbench

//  Core-local interruptor controller for the 0x02xx_xxxx device window of the memory map.

---
 rtl/bp_clint_ctrl.sv | 134 +++++++++++++
 tb/tb_bp_clint_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_clint_ctrl.sv
// Core-local interruptor: mtime counter, per-core mtimecmp/msip registers,
// a one-at-a-time MMIO load/store port and per-core timer/software interrupt lines.
module bp_clint_ctrl #(
    parameter int num_core_p    = 1,
    parameter int paddr_width_p = 56,
    parameter int tick_div_p    = 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     mmio_v_i,
    output logic                     mmio_ready_o,
    input  logic                     mmio_w_i,
    input  logic [paddr_width_p-1:0] mmio_addr_i,
    input  logic [63:0]              mmio_data_i,
    output logic                     resp_v_o,
    output logic [63:0]              resp_data_o,
    output logic                     resp_err_o,
    input  logic                     resp_yumi_i,
    output logic [num_core_p-1:0]    timer_irq_o,
    output logic [num_core_p-1:0]    soft_irq_o
);
    localparam int                  cnt_w_lp     = (tick_div_p > 1) ? $clog2(tick_div_p) : 1;
    localparam logic [cnt_w_lp-1:0] tick_last_lp = cnt_w_lp'(tick_div_p - 1);
    localparam logic [23:0]         mtime_off_lp = 24'h00BFF8;

    typedef enum logic {IDLE, RESP} state_e;
    state_e state_q, state_d;

    logic [23:0]           offset;
    logic                  unused_addr_hi;
    logic [num_core_p-1:0] msip_hit;
    logic [num_core_p-1:0] cmp_hit;
    logic                  mtime_hit, any_hit, accept, store, tick, mtime_wr;
    logic [63:0]           rd_data;

    logic [cnt_w_lp-1:0]   tick_cnt_q, tick_cnt_d;
    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q [num_core_p];
    logic [num_core_p-1:0] msip_q;
    logic [num_core_p-1:0] timer_irq_q;
    logic [63:0]           resp_data_q, resp_data_d;
    logic                  resp_err_q, resp_err_d;

    // Only the low 24 bits select a register; the device window is decoded upstream.
    assign offset         = mmio_addr_i[23:0];
    assign unused_addr_hi = ^mmio_addr_i[paddr_width_p-1:24];

    for (genvar gi = 0; gi < num_core_p; gi++) begin : g_dec
        assign msip_hit[gi] = (offset == 24'(4 * gi));
        assign cmp_hit[gi]  = (offset == 24'(24'h004000 + 8 * gi));
    end

    assign mtime_hit = (offset == mtime_off_lp);
    assign any_hit   = (|msip_hit) | (|cmp_hit) | mtime_hit;
    assign accept    = (state_q == IDLE) & mmio_v_i;
    assign store     = accept & mmio_w_i;
    assign tick      = (tick_cnt_q == tick_last_lp);
    assign mtime_wr  = store & mtime_hit;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < num_core_p; i++) begin
            if (msip_hit[i]) rd_data = {63'd0, msip_q[i]};
            if (cmp_hit[i])  rd_data = mtimecmp_q[i];
        end
        if (mtime_hit) rd_data = mtime_q;
    end

    // A software write to mtime overrides a coincident tick and restarts the divider.
    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + cnt_w_lp'(1);
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        if (mtime_wr) begin
            tick_cnt_d = '0;
            mtime_d    = mmio_data_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            IDLE: begin
                if (mmio_v_i) begin
                    state_d     = RESP;
                    resp_err_d  = ~any_hit;
                    resp_data_d = mmio_w_i ? '0 : rd_data;
                end
            end
            RESP: begin
                if (resp_yumi_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            mtime_q     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            mtime_q     <= mtime_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            msip_q      <= '0;
            timer_irq_q <= '0;
            for (int i = 0; i < num_core_p; i++) mtimecmp_q[i] <= '1;
        end else begin
            for (int i = 0; i < num_core_p; i++) begin
                if (store && msip_hit[i]) msip_q[i] <= mmio_data_i[0];
                if (store && cmp_hit[i])  mtimecmp_q[i] <= mmio_data_i;
                timer_irq_q[i] <= (mtime_q >= mtimecmp_q[i]);
            end
        end
    end

    assign mmio_ready_o = (state_q == IDLE);
    assign resp_v_o     = (state_q == RESP);
    assign resp_data_o  = resp_data_q;
    assign resp_err_o   = resp_err_q;
    assign timer_irq_o  = timer_irq_q;
    assign soft_irq_o   = msip_q;
endmodule

// File: tb/tb_bp_clint_ctrl.sv
// Scoreboarded bench for bp_clint_ctrl: one instance with default parameters,
// one with two cores and a divide-by-4 tick.
module tb_bp_clint_ctrl;
    typedef struct {
        logic [63:0] data;
        logic        err;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        v [2];
    logic        ready [2];
    logic        w [2];
    logic        rv [2];
    logic        rerr [2];
    logic        yumi [2];
    logic [55:0] addr [2];
    logic [63:0] wdata [2];
    logic [63:0] rdata [2];
    logic [0:0]  tirq0, sirq0;
    logic [1:0]  tirq1, sirq1;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int checks = 0;
    int errors = 0;
    int txn = 0;
    longint unsigned cyc;
    longint unsigned mark;

    bp_clint_ctrl #(.num_core_p(1), .paddr_width_p(56), .tick_div_p(1)) dut0 (
        .clk_i(clk), .reset_i(rst),
        .mmio_v_i(v[0]), .mmio_ready_o(ready[0]), .mmio_w_i(w[0]),
        .mmio_addr_i(addr[0]), .mmio_data_i(wdata[0]),
        .resp_v_o(rv[0]), .resp_data_o(rdata[0]), .resp_err_o(rerr[0]),
        .resp_yumi_i(yumi[0]), .timer_irq_o(tirq0), .soft_irq_o(sirq0)
    );

    bp_clint_ctrl #(.num_core_p(2), .paddr_width_p(56), .tick_div_p(4)) dut1 (
        .clk_i(clk), .reset_i(rst),
        .mmio_v_i(v[1]), .mmio_ready_o(ready[1]), .mmio_w_i(w[1]),
        .mmio_addr_i(addr[1]), .mmio_data_i(wdata[1]),
        .resp_v_o(rv[1]), .resp_data_o(rdata[1]), .resp_err_o(rerr[1]),
        .resp_yumi_i(yumi[1]), .timer_irq_o(tirq1), .soft_irq_o(sirq1)
    );

    // Cycles since reset release; equals dut0's mtime while it is never written.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   sz;
        for (int d = 0; d < 2; d++) begin
            if (!rst && rv[d] && yumi[d]) begin
                sz = (d == 0) ? exp_q0.size() : exp_q1.size();
                if (sz == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp dut%0d: got data 0x%h err %0d, expected no response",
                             d, rdata[d], rerr[d]);
                end else begin
                    e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    $display("dut%0d txn%0d resp data=0x%h err=%0d", d, e.id, rdata[d], rerr[d]);
                    chk($sformatf("txn%0d_data", e.id), rdata[d], e.data);
                    chk($sformatf("txn%0d_err", e.id), {63'd0, rerr[d]}, {63'd0, e.err});
                end
            end
        end
    end

    task automatic do_req(input int d, input logic wr, input logic [23:0] off,
                          input logic [63:0] wd, input logic [63:0] ed,
                          input logic ee, input bit use_cyc);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        v[d]     = 1'b1;
        w[d]     = wr;
        addr[d]  = {32'h0000_0002, off};
        wdata[d] = wd;
        while (!ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready[d]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d: got ready 0 after 50 cycles, expected 1", d);
            v[d] = 1'b0;
            return;
        end
        e.data = use_cyc ? cyc : ed;
        e.err  = ee;
        e.id   = txn++;
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        @(posedge clk);
        #1;
        v[d] = 1'b0;
    endtask

    task automatic wait_drain(input int d);
        int n = 0;
        while (((d == 0) ? exp_q0.size() : exp_q1.size()) != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (((d == 0) ? exp_q0.size() : exp_q1.size()) != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout dut%0d: got pending responses, expected none", d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            v[d] = 1'b0; w[d] = 1'b0; addr[d] = '0; wdata[d] = '0; yumi[d] = 1'b1;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, ready[0]}, 64'd1);
        chk("rst_resp_v", {63'd0, rv[0]}, 64'd0);
        chk("rst_resp_data", rdata[0], 64'd0);
        chk("rst_resp_err", {63'd0, rerr[0]}, 64'd0);
        chk("rst_irqs", {60'd0, tirq1, sirq1}, 64'd0);
        chk("rst_irqs0", {62'd0, tirq0, sirq0}, 64'd0);
        rst = 1'b0;

        // mtime counts accept cycles; mtimecmp resets to all ones
        repeat (5) @(negedge clk);
        do_req(0, 1'b0, 24'h00BFF8, 64'd0, 64'd0, 1'b0, 1'b1);
        do_req(0, 1'b0, 24'h004000, 64'd0, '1, 1'b0, 1'b0);
        wait_drain(0);
        chk("t1_timer_irq", {63'd0, tirq0}, 64'd0);

        // mtimecmp=20 with mtime reset to 0
        do_req(0, 1'b1, 24'h00BFF8, 64'd0, 64'd0, 1'b0, 1'b0);
        mark = cyc;
        do_req(0, 1'b1, 24'h004000, 64'd20, 64'd0, 1'b0, 1'b0);
        n = 0;
        while (cyc - mark < 20 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t2_mtime_at_20", cyc - mark, 64'd20);
        chk("t2_irq_at_20", {63'd0, tirq0}, 64'd0);
        @(negedge clk);
        chk("t2_irq_at_21", {63'd0, tirq0}, 64'd1);
        do_req(0, 1'b1, 24'h004000, '1, 64'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t2_irq_hold", {63'd0, tirq0}, 64'd1);
        @(negedge clk);
        chk("t2_irq_fall", {63'd0, tirq0}, 64'd0);

        // msip: only bit 0 is stored
        do_req(0, 1'b1, 24'h000000, 64'h3, 64'd0, 1'b0, 1'b0);
        chk("t3_soft_rise", {63'd0, sirq0}, 64'd1);
        do_req(0, 1'b0, 24'h000000, 64'd0, 64'd1, 1'b0, 1'b0);
        do_req(0, 1'b1, 24'h000000, 64'd0, 64'd0, 1'b0, 1'b0);
        chk("t3_soft_fall", {63'd0, sirq0}, 64'd0);
        do_req(0, 1'b1, 24'h000000, 64'h2, 64'd0, 1'b0, 1'b0);
        do_req(0, 1'b0, 24'h000000, 64'd0, 64'd0, 1'b0, 1'b0);

        // unmapped offsets and out-of-range core index
        do_req(0, 1'b0, 24'h000100, 64'd0, 64'd0, 1'b1, 1'b0);
        do_req(0, 1'b1, 24'h004008, 64'h1234, 64'd0, 1'b1, 1'b0);
        do_req(0, 1'b0, 24'h004008, 64'd0, 64'd0, 1'b1, 1'b0);
        do_req(0, 1'b0, 24'h000004, 64'd0, 64'd0, 1'b1, 1'b0);
        do_req(0, 1'b0, 24'h004000, 64'd0, '1, 1'b0, 1'b0);
        wait_drain(0);

        // second core on the two-core instance
        do_req(1, 1'b1, 24'h004008, 64'h55, 64'd0, 1'b0, 1'b0);
        do_req(1, 1'b0, 24'h004008, 64'd0, 64'h55, 1'b0, 1'b0);
        do_req(1, 1'b0, 24'h000008, 64'd0, 64'd0, 1'b1, 1'b0);
        do_req(1, 1'b1, 24'h000004, 64'd1, 64'd0, 1'b0, 1'b0);
        chk("core1_soft", {62'd0, sirq1}, 64'h2);

        // mtime wrap with divide-by-4 tick
        do_req(1, 1'b1, 24'h004000, 64'd5, 64'd0, 1'b0, 1'b0);
        do_req(1, 1'b1, 24'h00BFF8, '1, 64'd0, 1'b0, 1'b0);
        do_req(1, 1'b0, 24'h00BFF8, 64'd0, '1, 1'b0, 1'b0);
        do_req(1, 1'b0, 24'h00BFF8, 64'd0, '1, 1'b0, 1'b0);
        do_req(1, 1'b0, 24'h00BFF8, 64'd0, 64'd0, 1'b0, 1'b0);
        wait_drain(1);
        chk("t4_irq_after_wrap", {63'd0, tirq1[0]}, 64'd0);

        // stalled response, then reset mid-response
        do_req(0, 1'b1, 24'h004000, 64'd7, 64'd0, 1'b0, 1'b0);
        do_req(0, 1'b1, 24'h000000, 64'd1, 64'd0, 1'b0, 1'b0);
        wait_drain(0);
        yumi[0] = 1'b0;
        do_req(0, 1'b0, 24'h004000, 64'd0, 64'd7, 1'b0, 1'b0);
        v[0] = 1'b1; w[0] = 1'b0; addr[0] = {32'h0000_0002, 24'h00BFF8};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("t6_ready_%0d", i), {63'd0, ready[0]}, 64'd0);
            chk($sformatf("t6_resp_v_%0d", i), {63'd0, rv[0]}, 64'd1);
            chk($sformatf("t6_data_%0d", i), rdata[0], 64'd7);
        end
        rst = 1'b1;
        #1;
        chk("t6_rst_resp_v", {63'd0, rv[0]}, 64'd0);
        chk("t6_rst_ready", {63'd0, ready[0]}, 64'd1);
        chk("t6_rst_data", rdata[0], 64'd0);
        chk("t6_rst_soft", {63'd0, sirq0}, 64'd0);
        v[0] = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        @(negedge clk);
        rst = 1'b0;
        yumi[0] = 1'b1;
        repeat (2) @(negedge clk);
        do_req(0, 1'b0, 24'h00BFF8, 64'd0, 64'd0, 1'b0, 1'b1);
        do_req(0, 1'b0, 24'h004000, 64'd0, '1, 1'b0, 1'b0);
        do_req(0, 1'b0, 24'h000000, 64'd0, 64'd0, 1'b0, 1'b0);
        wait_drain(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
